// File: rtl/pulse_seq_pkg.sv
// Shared types, constants and the channel-search helper for the pulse_seq firing engine.
// The PULSE_SEQ_ARM_KEY_EN build option gates start acceptance on ARM_KEY.
package pulse_seq_pkg;

  localparam int          CH_IDX_W = 4;
  localparam int          MAX_CH   = 16;
  localparam logic [15:0] ARM_KEY  = 16'hA5C3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PULSE  = 3'd1,
    ST_GAP    = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  typedef struct packed {
    logic                found;
    logic [CH_IDX_W-1:0] idx;
  } ch_sel_t;

  // Lowest set bit of mask at or above index 'from'; found=0 when there is none.
  function automatic ch_sel_t find_from(input logic [MAX_CH-1:0] mask,
                                        input logic [CH_IDX_W:0]  from);
    ch_sel_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r.found = 1'b1;
        r.idx   = CH_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_seq_if.sv
// Control/status bundle between the pulse_seq register slave (master) and the core (slave).
// arm_key exists only when PULSE_SEQ_ARM_KEY_EN is defined.
interface pulse_seq_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int REP_W  = 8
);
  import pulse_seq_pkg::*;

  logic                start;
  logic                abort;
  logic [NUM_CH-1:0]   ch_mask;
  logic [CNT_W-1:0]    pulse_len;
  logic [CNT_W-1:0]    gap_len;
  logic [REP_W-1:0]    rep_cnt;
  logic [NUM_CH-1:0]   fire_out;
  logic                busy;
  logic                done;
  logic                err;
  logic [CH_IDX_W-1:0] cur_ch;
`ifdef PULSE_SEQ_ARM_KEY_EN
  logic [15:0]         arm_key;
`endif

  modport master (
`ifdef PULSE_SEQ_ARM_KEY_EN
    output arm_key,
`endif
    output start, abort, ch_mask, pulse_len, gap_len, rep_cnt,
    input  fire_out, busy, done, err, cur_ch
  );

  modport slave (
`ifdef PULSE_SEQ_ARM_KEY_EN
    input  arm_key,
`endif
    input  start, abort, ch_mask, pulse_len, gap_len, rep_cnt,
    output fire_out, busy, done, err, cur_ch
  );

endinterface

// File: rtl/pulse_seq_timer.sv
// Loadable down-counter shared by the pulse and gap phases; zero flags the final cycle.
module pulse_seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset)                   cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && (cnt != '0))  cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_seq_core.sv
// Firing-sequence engine: one-hot pulses over the latched channel mask, ascending, with repeats.
// Define PULSE_SEQ_ARM_KEY_EN to require arm_key == ARM_KEY alongside start.
module pulse_seq_core
  import pulse_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int REP_W  = 8
) (
  input logic       clock,
  input logic       reset,
  pulse_seq_if.slave bus
);

  // Legacy-compatible state constants taken from the package enum.
  localparam logic [2:0] IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] PULSE  = 3'(ST_PULSE);
  localparam logic [2:0] GAP    = 3'(ST_GAP);
  localparam logic [2:0] NEXT   = 3'(ST_NEXT);
  localparam logic [2:0] FINISH = 3'(ST_FINISH);

  logic [2:0]        state;
  logic [NUM_CH-1:0] mask_s;
  logic [CNT_W-1:0]  plen_s;
  logic [CNT_W-1:0]  glen_s;
  logic [REP_W-1:0]  pass_cnt;

  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_zero;
  logic [CNT_W-1:0]  tmr_val;

  ch_sel_t first_in, first_s, next_s;
  logic    key_ok, start_ok, accept, reject, armed;

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_IDX_W-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

  assign first_in = find_from(MAX_CH'(bus.ch_mask), '0);
  assign first_s  = find_from(MAX_CH'(mask_s), '0);
  assign next_s   = find_from(MAX_CH'(mask_s),
                              (CH_IDX_W+1)'(bus.cur_ch) + (CH_IDX_W+1)'(1));

`ifdef PULSE_SEQ_ARM_KEY_EN
  assign key_ok = (bus.arm_key == ARM_KEY);
`else
  assign key_ok = 1'b1;
`endif

  // abort takes precedence over a coincident start.
  assign start_ok = bus.start && !bus.abort && (state == IDLE);
  assign accept   = start_ok && key_ok && first_in.found && (bus.pulse_len != '0);
  assign reject   = start_ok && !accept;
  assign tmr_en   = (state == PULSE) || (state == GAP);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE:  if (accept) begin
               tmr_load = 1'b1;
               tmr_val  = bus.pulse_len - CNT_W'(1);
             end
      PULSE: if (tmr_zero && (glen_s != '0)) begin
               tmr_load = 1'b1;
               tmr_val  = glen_s - CNT_W'(1);
             end
      NEXT:  if (next_s.found || (pass_cnt != '0)) begin
               tmr_load = 1'b1;
               tmr_val  = plen_s - CNT_W'(1);
             end
      default: ;
    endcase
  end

  pulse_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // NOTE: shadow registers are reset too, keeping simulation free of X after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      bus.fire_out <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.cur_ch   <= '0;
      mask_s       <= '0;
      plen_s       <= '0;
      glen_s       <= '0;
      pass_cnt     <= '0;
      armed        <= 1'b0;
    end else if (bus.abort && (state != IDLE)) begin
      state        <= IDLE;
      bus.fire_out <= '0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b1;
      bus.done     <= 1'b0;
      armed        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mask_s       <= bus.ch_mask;
            plen_s       <= bus.pulse_len;
            glen_s       <= bus.gap_len;
            pass_cnt     <= bus.rep_cnt;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.busy     <= 1'b1;
            bus.cur_ch   <= first_in.idx;
            bus.fire_out <= onehot(first_in.idx);
            armed        <= 1'b1;
            state        <= PULSE;
          end else if (reject) begin
            bus.err <= 1'b1;
          end
        end
        PULSE: if (tmr_zero) begin
          bus.fire_out <= '0;
          state        <= (glen_s == '0) ? NEXT : GAP;
        end
        GAP: if (tmr_zero) state <= NEXT;
        NEXT: begin
          if (next_s.found) begin
            bus.cur_ch   <= next_s.idx;
            bus.fire_out <= armed ? onehot(next_s.idx) : '0;
            state        <= PULSE;
          end else if ((pass_cnt != '0) && first_s.found) begin
            pass_cnt     <= pass_cnt - REP_W'(1);
            bus.cur_ch   <= first_s.idx;
            bus.fire_out <= armed ? onehot(first_s.idx) : '0;
            state        <= PULSE;
          end else begin
            state <= FINISH;
          end
        end
        FINISH: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          armed    <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_seq_core.sv
// Directed and randomized bench for pulse_seq_core against a trace-building reference model.
// Define PULSE_SEQ_ARM_KEY_EN to also exercise the arm-key gate.
module tb_pulse_seq_core;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int REP_W  = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pulse_seq_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .REP_W(REP_W)) bus ();

  pulse_seq_core #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NUM_CH-1:0] fire;
    int                ch;   // -1 on cycles with no pulse
  } step_t;

  step_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle output, straight from the rules: each pass visits the set channels in
  // ascending order, pulse_len high cycles, gap_len idle cycles, one bookkeeping cycle, then
  // one finishing cycle at the very end.
  task automatic build_trace(input logic [NUM_CH-1:0] mask, input int plen, input int glen,
                             input int rep);
    step_t s;
    exp_q.delete();
    for (int p = 0; p <= rep; p++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask[c]) begin
          for (int k = 0; k < plen; k++) begin
            s.fire = NUM_CH'(1 << c); s.ch = c; exp_q.push_back(s);
          end
          for (int k = 0; k < glen + 1; k++) begin
            s.fire = '0; s.ch = -1; exp_q.push_back(s);
          end
        end
      end
    end
    s.fire = '0; s.ch = -1; exp_q.push_back(s);
  endtask

  task automatic set_cfg(input logic [NUM_CH-1:0] mask, input int plen, input int glen,
                         input int rep);
    bus.ch_mask   = mask;
    bus.pulse_len = CNT_W'(plen);
    bus.gap_len   = CNT_W'(glen);
    bus.rep_cnt   = REP_W'(rep);
  endtask

  // Entered and left at a negative edge; meddle rewrites the config and restarts mid-run.
  task automatic run_seq(input logic [NUM_CH-1:0] mask, input int plen, input int glen,
                         input int rep, input bit meddle);
    build_trace(mask, plen, glen, rep);
    set_cfg(mask, plen, glen, rep);
    bus.start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      bus.start = 1'b0;
      check("fire_out", 32'(bus.fire_out), 32'(exp_q[i].fire));
      check("busy", 32'(bus.busy), 32'd1);
      if (exp_q[i].ch >= 0) check("cur_ch", 32'(bus.cur_ch), 32'(exp_q[i].ch));
      if (i == 0) begin
        check("err_cleared", 32'(bus.err), 32'd0);
        check("done_cleared", 32'(bus.done), 32'd0);
      end
      if (meddle && i == 1) begin
        set_cfg('1, 10, 7, 3);
        bus.start = 1'b1;
      end
    end
    @(negedge clock);
    check("end_busy", 32'(bus.busy), 32'd0);
    check("end_done", 32'(bus.done), 32'd1);
    check("end_err", 32'(bus.err), 32'd0);
    check("end_fire", 32'(bus.fire_out), 32'd0);
  endtask

  task automatic reject_start(input logic [NUM_CH-1:0] mask, input int plen, input string tag);
    set_cfg(mask, plen, 2, 0);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check({tag, "_err"}, 32'(bus.err), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_fire"}, 32'(bus.fire_out), 32'd0);
    repeat (3) @(negedge clock);
    check({tag, "_fire_later"}, 32'(bus.fire_out), 32'd0);
    check({tag, "_busy_later"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg('0, 0, 0, 0);
`ifdef PULSE_SEQ_ARM_KEY_EN
    bus.arm_key = pulse_seq_pkg::ARM_KEY;
`endif
    repeat (3) @(negedge clock);
    check("rst_fire", 32'(bus.fire_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_cur_ch", 32'(bus.cur_ch), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Two channels with a gap, then a single channel repeated back to back.
    run_seq(4'b0101, 3, 2, 0, 1'b0);
    run_seq(4'b1000, 1, 0, 2, 1'b0);

    // Rejected starts: empty mask, then zero pulse length.
    reject_start(4'b0000, 3, "rej_mask");
    run_seq(4'b0010, 2, 1, 0, 1'b0);
    reject_start(4'b0001, 0, "rej_plen");

    // Abort mid-pulse, then a valid start clears err.
    set_cfg(4'b0110, 5, 1, 0);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    check("pre_abort_fire", 32'(bus.fire_out), 32'b0010);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("abort_fire", 32'(bus.fire_out), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_err", 32'(bus.err), 32'd1);
    check("abort_done", 32'(bus.done), 32'd0);
    repeat (4) @(negedge clock);
    check("abort_stays_idle", 32'(bus.fire_out), 32'd0);
    run_seq(4'b0011, 2, 0, 1, 1'b0);

    // Abort while idle changes nothing.
    bus.abort = 1'b1;
    repeat (2) @(negedge clock);
    bus.abort = 1'b0;
    check("idle_abort_done", 32'(bus.done), 32'd1);
    check("idle_abort_err", 32'(bus.err), 32'd0);
    check("idle_abort_busy", 32'(bus.busy), 32'd0);

    // Config rewrite plus restart during a run leaves the run untouched.
    run_seq(4'b1001, 3, 1, 0, 1'b1);

    // Mid-run reset clears every output.
    set_cfg(4'b1100, 4, 1, 0);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    check("pre_reset_cur_ch", 32'(bus.cur_ch), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_fire", 32'(bus.fire_out), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    check("mid_rst_cur_ch", 32'(bus.cur_ch), 32'd0);
    repeat (3) @(negedge clock);
    check("post_rst_fire", 32'(bus.fire_out), 32'd0);

`ifdef PULSE_SEQ_ARM_KEY_EN
    bus.arm_key = 16'h0000;
    reject_start(4'b0001, 2, "rej_key");
    bus.arm_key = pulse_seq_pkg::ARM_KEY;
    run_seq(4'b0001, 2, 1, 0, 1'b0);
`endif

    // Randomized runs.
    for (int n = 0; n < 20; n++) begin
      logic [NUM_CH-1:0] m;
      m = NUM_CH'($urandom_range(15, 1));
      run_seq(m, int'($urandom_range(4, 1)), int'($urandom_range(3, 0)),
              int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
